gain_controller: RTL and testbench

Sequencer for the mixer's gain path. It debounces the two gain push-keys, keeps a gain level from 0 to GAIN_MAX, and shows that level on one 7-segment digit. It also passes each audio sample from the codec input stream to the codec output stream, scaling it through a valid/ready handshake. It sits between the audio core's ADC-side stream and its DAC-side stream, and is the only owner of the gain key and gain hex pins.

---
 rtl/gain_controller.sv | 217 +++++++++++++++++++++
 tb/tb_gain_controller.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gain_controller.sv
`default_nettype none
// ============================================================================
// Module   : gain_controller
// Purpose  : Gain-path sequencer for the mixer. Debounces the two gain
//            push-keys, holds a gain step 0..GAIN_MAX, shows it on one
//            active-low 7-segment digit, and scales each audio sample by
//            gain/4 between a valid/ready sink and a valid/ready source.
// Ports    : clk_clk             - system clock (only clock)
//            reset_reset         - synchronous active-high reset
//            gain_key_new_signal - raw active-low keys, [0]=down, [1]=up
//            gain_hex_new_signal - active-low segments, bit 6..0 = g..a
//            sink_data/valid/ready     - input sample stream
//            source_data/valid/ready   - scaled output sample stream
// Options  : GAIN_SAT_EN - when defined, out-of-range results clamp to the
//            signed DATA_W limits; otherwise the low DATA_W bits wrap.
// Revision : 1.0 - initial release
// ============================================================================
module gain_controller #(
  parameter int DATA_W          = 24,
  parameter int GAIN_MAX        = 8,
  parameter int GAIN_INIT       = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [1:0]        gain_key_new_signal,
  output logic [6:0]        gain_hex_new_signal,
  input  logic [DATA_W-1:0] sink_data,
  input  logic              sink_valid,
  output logic              sink_ready,
  output logic [DATA_W-1:0] source_data,
  output logic              source_valid,
  input  logic              source_ready
);

  localparam int          CNT_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]  GAIN_TOP   = 4'(GAIN_MAX);
  localparam logic [3:0]  GAIN_RST   = 4'(GAIN_INIT);
  localparam int          PROD_W     = DATA_W + 4;

  // Decimal digit to active-low segment pattern (g..a); blank above 9.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Key path: synchronizer, debounce counter, press-event pulse per key
  // --------------------------------------------------------------------------
  logic [1:0] w_press;

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        deb_q   <= 1'b1;
        press_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= gain_key_new_signal[k];
        sync2_q <= sync1_q;
        press_q <= 1'b0;
        if (sync2_q == deb_q) begin
          // Agreement restarts the stability window.
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_q   <= '0;
          deb_q   <= sync2_q;
          // Only the released->pressed edge counts as an event.
          press_q <= ~sync2_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign w_press[k] = press_q;
  end

  // --------------------------------------------------------------------------
  // Gain register and hex display
  // --------------------------------------------------------------------------
  logic [3:0] gain_q, gain_d;
  logic [6:0] hex_q;

  always_comb begin
    gain_d = gain_q;
    if (w_press[1] && !w_press[0] && (gain_q != GAIN_TOP)) begin
      gain_d = gain_q + 4'd1;
    end else if (w_press[0] && !w_press[1] && (gain_q != 4'd0)) begin
      gain_d = gain_q - 4'd1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      gain_q <= GAIN_RST;
      hex_q  <= seg7(GAIN_RST);
    end else begin
      gain_q <= gain_d;
      hex_q  <= seg7(gain_q);
    end
  end

  assign gain_hex_new_signal = hex_q;

  // --------------------------------------------------------------------------
  // Sample datapath
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCALE = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  state_t             state_q;
  logic [DATA_W-1:0]  sample_q;
  logic [3:0]         gain_s_q;
  logic [DATA_W-1:0]  src_data_q;
  logic               src_valid_q;
  logic               rdy_q;

  logic signed [PROD_W-1:0] w_samp_ext;
  logic signed [PROD_W-1:0] w_gain_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_shift;
  logic        [DATA_W-1:0] w_result;

  assign w_samp_ext = {{4{sample_q[DATA_W-1]}}, sample_q};
  assign w_gain_ext = {{(PROD_W-4){1'b0}}, gain_s_q};
  assign w_prod     = w_samp_ext * w_gain_ext;
  // Gain step 4 is unity, so the factor is gain/4 (floor for negatives).
  assign w_shift    = w_prod >>> 2;

`ifdef GAIN_SAT_EN
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  logic w_in_range;
  // In range when every bit above the DATA_W sign bit matches it.
  assign w_in_range = (&w_shift[PROD_W-1:DATA_W-1]) | ~(|w_shift[PROD_W-1:DATA_W-1]);
  assign w_result   = w_in_range ? w_shift[DATA_W-1:0]
                                 : (w_shift[PROD_W-1] ? SAT_MIN : SAT_MAX);
`else
  logic [PROD_W-DATA_W-1:0] w_unused_hi;
  assign w_unused_hi = w_shift[PROD_W-1:DATA_W];
  assign w_result    = w_shift[DATA_W-1:0];
`endif

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= S_IDLE;
      sample_q    <= '0;
      gain_s_q    <= '0;
      src_data_q  <= '0;
      src_valid_q <= 1'b0;
      rdy_q       <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sink_valid) begin
            // Gain is frozen with the sample so later key presses
            // cannot affect a sample already accepted.
            sample_q <= sink_data;
            gain_s_q <= gain_q;
            rdy_q    <= 1'b0;
            state_q  <= S_SCALE;
          end
        end
        S_SCALE: begin
          src_data_q  <= w_result;
          src_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (source_ready) begin
            src_valid_q <= 1'b0;
            rdy_q       <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          src_valid_q <= 1'b0;
          rdy_q       <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // Masked by reset so the sink sees not-ready for the whole reset window.
  assign sink_ready   = rdy_q & ~reset_reset;
  assign source_data  = src_data_q;
  assign source_valid = src_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_gain_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_gain_controller
// Purpose  : Self-checking bench for gain_controller with a short debounce
//            window; samples are checked against an arithmetic gain model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gain_controller;

  localparam int DW = 24;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    keys;
  logic [6:0]    hex;
  logic [DW-1:0] sdata;
  logic          svalid;
  logic          sready;
  logic [DW-1:0] odata;
  logic          ovalid;
  logic          oready;

  int total = 0;
  int bad   = 0;
  int model_gain;

  logic [6:0] hex_tab [10];

  always #5 clk = ~clk;

  gain_controller #(
    .DATA_W(DW), .GAIN_MAX(8), .GAIN_INIT(4), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk_clk(clk),
    .reset_reset(rst),
    .gain_key_new_signal(keys),
    .gain_hex_new_signal(hex),
    .sink_data(sdata),
    .sink_valid(svalid),
    .sink_ready(sready),
    .source_data(odata),
    .source_valid(ovalid),
    .source_ready(oready)
  );

  // Reference: out = floor(x * g / 4), then clamp or wrap to DW bits.
  function automatic logic [DW-1:0] ref_scale(input logic [DW-1:0] x, input int g);
    longint p;
    longint r;
    longint lim_hi;
    longint lim_lo;
    lim_hi = (longint'(1) <<< (DW - 1)) - 1;
    lim_lo = -(longint'(1) <<< (DW - 1));
    p = longint'($signed(x)) * longint'(g);
    r = p >>> 2;
`ifdef GAIN_SAT_EN
    if (r > lim_hi) r = lim_hi;
    if (r < lim_lo) r = lim_lo;
`else
    if (lim_hi < lim_lo) r = 0;
`endif
    return r[DW-1:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One transaction with source_ready held high; returns what was observed.
  task automatic run_sample(input logic [DW-1:0] x, output logic to,
                            output logic v1, output logic v2, output logic [DW-1:0] d);
    to = 1'b1;
    v1 = 1'bx;
    v2 = 1'bx;
    d  = 'x;
    oready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sready === 1'b1) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    if (!to) begin
      sdata  = x;
      svalid = 1'b1;
      tick();
      svalid = 1'b0;
      v1 = ovalid;
      tick();
      v2 = ovalid;
      d  = odata;
      tick();
    end
  endtask

  task automatic press(input int idx);
    keys[idx] = 1'b0;
    repeat (8) tick();
    keys[idx] = 1'b1;
    repeat (8) tick();
    if (idx == 1 && model_gain < 8) model_gain++;
    if (idx == 0 && model_gain > 0) model_gain--;
  endtask

  task automatic press_both;
    keys = 2'b00;
    repeat (8) tick();
    keys = 2'b11;
    repeat (8) tick();
  endtask

  task automatic random_samples(input string tag, input int n);
    logic to, v1, v2;
    logic [DW-1:0] d, x, e;
    for (int i = 0; i < n; i++) begin
      x = DW'($urandom());
      e = ref_scale(x, model_gain);
      run_sample(x, to, v1, v2, d);
      total++;
      if (to || v1 !== 1'b0 || v2 !== 1'b1 || d !== e) begin
        bad++;
        $display("FAIL %s: gain=%0d in=%h got to=%b v1=%b v2=%b out=%h, want v1=0 v2=1 out=%h",
                 tag, model_gain, x, to, v1, v2, d, e);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; keys = 2'b11; svalid = 1'b0; sdata = '0; oready = 1'b1;
    tick(); tick();
    total++;
    if (sready !== 1'b0) begin
      bad++; $display("FAIL reset_ready_low: got %b want 0", sready);
    end
    rst = 1'b0;
    #1;
    model_gain = 4;
    total++;
    if (sready !== 1'b1 || ovalid !== 1'b0 || odata !== '0 || hex !== 7'h19) begin
      bad++;
      $display("FAIL reset_state: ready=%b valid=%b data=%h hex=%h want 1 0 000000 19",
               sready, ovalid, odata, hex);
    end
  endtask

  task automatic test_basic;
    logic to, v1, v2;
    logic [DW-1:0] d;
    run_sample(24'h123456, to, v1, v2, d);
    total++;
    if (to || v1 !== 1'b0 || v2 !== 1'b1 || d !== 24'h123456) begin
      bad++;
      $display("FAIL unity_gain: to=%b v1=%b v2=%b out=%h want 0 1 123456", to, v1, v2, d);
    end
    random_samples("rand_gain4", 6);
  endtask

  task automatic test_glitch;
    for (int w = 1; w <= 3; w++) begin
      keys[1] = 1'b0;
      repeat (w) tick();
      keys[1] = 1'b1;
      repeat (10) tick();
      total++;
      if (hex !== hex_tab[model_gain]) begin
        bad++; $display("FAIL glitch_w%0d: hex=%h want %h", w, hex, hex_tab[model_gain]);
      end
    end
  endtask

  task automatic test_key_latency;
    int n;
    n = 0;
    keys[1] = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      n = i;
      if (hex !== 7'h19) break;
    end
    keys[1] = 1'b1;
    repeat (8) tick();
    model_gain = 5;
    total++;
    if (n != DB + 4 || hex !== 7'h12) begin
      bad++; $display("FAIL key_latency: cycles=%0d hex=%h want %0d 12", n, hex, DB + 4);
    end
  endtask

  task automatic test_up_clamp;
    for (int i = 0; i < 4; i++) press(1);
    total++;
    if (model_gain != 8 || hex !== 7'h00) begin
      bad++; $display("FAIL up_clamp: hex=%h want 00", hex);
    end
  endtask

  task automatic test_saturation;
    logic to, v1, v2;
    logic [DW-1:0] d, e1, e2;
`ifdef GAIN_SAT_EN
    e1 = 24'h7FFFFF;
    e2 = 24'h800000;
`else
    e1 = 24'h800000;
    e2 = 24'h7FFFFE;
`endif
    run_sample(24'h400000, to, v1, v2, d);
    total++;
    if (to || v2 !== 1'b1 || d !== e1) begin
      bad++; $display("FAIL sat_pos: out=%h want %h", d, e1);
    end
    run_sample(24'hBFFFFF, to, v1, v2, d);
    total++;
    if (to || v2 !== 1'b1 || d !== e2) begin
      bad++; $display("FAIL sat_neg: out=%h want %h", d, e2);
    end
    random_samples("rand_gain8", 6);
  endtask

  task automatic test_down_and_both;
    press(0);
    total++;
    if (hex !== 7'h78) begin
      bad++; $display("FAIL down_once: hex=%h want 78", hex);
    end
    press_both();
    total++;
    if (hex !== 7'h78) begin
      bad++; $display("FAIL both_keys: hex=%h want 78", hex);
    end
    random_samples("rand_gain7", 4);
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] q[$];
    logic [DW-1:0] e, x, stall_exp;
    int accepts, outs;
    // Streaming throughput with source_ready held high.
    oready = 1'b1; accepts = 0; outs = 0;
    sdata = DW'($urandom()); svalid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (sready === 1'b1) begin
        accepts++;
        q.push_back(ref_scale(sdata, model_gain));
      end
      tick();
      if (sready === 1'b1 && accepts > 0) sdata = DW'($urandom());
      if (ovalid === 1'b1) begin
        outs++;
        e = (q.size() > 0) ? q.pop_front() : '0;
        total++;
        if (odata !== e) begin
          bad++; $display("FAIL stream_data: out=%h want %h", odata, e);
        end
      end
    end
    svalid = 1'b0;
    repeat (3) tick();
    total++;
    if (accepts != 4) begin
      bad++; $display("FAIL throughput: accepts=%0d in 12 cycles want 4", accepts);
    end
    // Stall: result must stay put while a gain press happens.
    oready = 1'b0;
    x = DW'($urandom());
    stall_exp = ref_scale(x, model_gain);
    sdata = x; svalid = 1'b1;
    tick();
    svalid = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      total++;
      if (ovalid !== 1'b1 || odata !== stall_exp || sready !== 1'b0) begin
        bad++;
        $display("FAIL stall_c%0d: valid=%b out=%h ready=%b want 1 %h 0",
                 i, ovalid, odata, sready, stall_exp);
      end
      tick();
    end
    press(0);
    total++;
    if (ovalid !== 1'b1 || odata !== stall_exp || hex !== 7'h02) begin
      bad++;
      $display("FAIL stall_press: valid=%b out=%h hex=%h want 1 %h 02", ovalid, odata, hex, stall_exp);
    end
    oready = 1'b1;
    tick();
    total++;
    if (ovalid !== 1'b0) begin
      bad++; $display("FAIL stall_release: valid=%b want 0", ovalid);
    end
    random_samples("after_stall_gain6", 3);
  endtask

  task automatic test_gain_zero;
    logic to, v1, v2;
    logic [DW-1:0] d;
    for (int i = 0; i < 7; i++) begin
      press(0);
      total++;
      if (hex !== hex_tab[model_gain]) begin
        bad++; $display("FAIL down_step%0d: hex=%h want %h", i, hex, hex_tab[model_gain]);
      end
    end
    total++;
    if (model_gain != 0 || hex !== 7'h40) begin
      bad++; $display("FAIL floor_zero: hex=%h want 40", hex);
    end
    run_sample(24'h7FFFFF, to, v1, v2, d);
    total++;
    if (to || v2 !== 1'b1 || d !== 24'h000000) begin
      bad++; $display("FAIL gain_zero: out=%h want 000000", d);
    end
    random_samples("rand_gain0", 3);
  endtask

  task automatic test_reset_in_flight;
    int seen;
    oready = 1'b0;
    sdata = 24'h2A2A2A; svalid = 1'b1;
    tick();
    svalid = 1'b0;
    tick();
    total++;
    if (ovalid !== 1'b1) begin
      bad++; $display("FAIL reach_out: valid=%b want 1", ovalid);
    end
    rst = 1'b1;
    tick();
    total++;
    if (ovalid !== 1'b0 || hex !== 7'h19 || sready !== 1'b0) begin
      bad++; $display("FAIL midreset: valid=%b hex=%h ready=%b want 0 19 0", ovalid, hex, sready);
    end
    rst = 1'b0;
    oready = 1'b1;
    model_gain = 4;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ovalid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL dropped_sample: valid seen %0d cycles want 0", seen);
    end
    random_samples("post_reset_gain4", 3);
  endtask

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    model_gain = 4;
    test_reset();
    test_basic();
    test_glitch();
    test_key_latency();
    test_up_clamp();
    test_saturation();
    test_down_and_both();
    test_back_to_back();
    test_gain_zero();
    test_reset_in_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
